// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to packed NxN convolution windows
// Line buffers feed the right column of a shifting register window; emits valid-only windows.
module conv_window_gen #(
    parameter int DWIDTH_DAT   = 8,
    parameter int DWIDTH_SLICE = 3,
    parameter int IMG_WIDTH    = 64,
    parameter int IMG_HEIGHT   = 64
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [DWIDTH_DAT-1:0]                        in_pix,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [DWIDTH_SLICE*DWIDTH_SLICE*DWIDTH_DAT-1:0] out_win,
    output logic                                         frame_done
);

    localparam int N  = DWIDTH_SLICE;
    localparam int DW = DWIDTH_DAT;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(N - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(N - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [DW-1:0] lb    [0:N-2][0:IMG_WIDTH-1];
    logic [DW-1:0] lb_rd [0:N-2];
    logic [DW-1:0] win_q [0:N-1][0:N-1];
    logic [DW-1:0] win_d [0:N-1][0:N-1];
    logic [N*N*DW-1:0] win_pack;

    logic accept;
    logic win_ok;
    logic last_pix;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign win_ok   = (row >= ROW_MIN) && (col >= COL_MIN);
    assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

    // Asynchronous read so the pre-write value at col feeds both the next buffer and the window.
    always_comb begin
        for (int k = 0; k < N - 1; k++) begin
            lb_rd[k] = lb[k][col];
        end
    end

    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < N - 1; r++) begin
            win_d[r][N-1] = lb_rd[N-2-r];
        end
        win_d[N-1][N-1] = in_pix;
    end

    always_comb begin
        win_pack = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                win_pack[(r*N+c)*DW +: DW] = win_d[r][c];
            end
        end
    end

    // Buffer contents need no reset: every emitted window overwrites what it reads first.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][col] <= in_pix;
            for (int k = 1; k < N - 1; k++) begin
                lb[k][col] <= lb[k-1][col];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_win    <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            frame_done <= accept && last_pix;
            if (accept) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        win_q[r][c] <= win_d[r][c];
                    end
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (win_ok) begin
                    out_win <= win_pack;
                end
            end
            if (accept && win_ok) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen
// Small 4x4 instance for frame/stall/gap/reset cases, 64x64 instance for throughput.
module tb_conv_window_gen;

    localparam int DW = 8;
    localparam int N  = 3;
    localparam int WW = N * N * DW;

    localparam logic [WW-1:0] W_FIRST = 72'h0a0908060504020100;
    localparam logic [WW-1:0] W_BP    = 72'h0b0a09070605030201;
    localparam logic [WW-1:0] W_3     = 72'h0e0d0c0a0908060504;
    localparam logic [WW-1:0] W_LAST  = 72'h0f0e0d0b0a09070605;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_frame_done;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
    logic [DW-1:0] a_in_pix, b_in_pix;
    logic [WW-1:0] a_out_win, b_out_win;

    conv_window_gen #(.DWIDTH_DAT(DW), .DWIDTH_SLICE(N), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pix(a_in_pix),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_win(a_out_win), .frame_done(a_frame_done));

    conv_window_gen #(.DWIDTH_DAT(DW), .DWIDTH_SLICE(N), .IMG_WIDTH(64), .IMG_HEIGHT(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pix(b_in_pix),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_win(b_out_win), .frame_done(b_frame_done));

    int checks = 0;
    int errors = 0;
    logic [WW-1:0] a_q[$];
    logic [WW-1:0] b_q[$];
    logic [WW-1:0] a_log[$];
    int a_mrow = 0, a_mcol = 0, b_mrow = 0, b_mcol = 0;
    int a_wins = 0, b_wins = 0, a_fd = 0, b_fd = 0;

    typedef struct packed {
        logic [DW-1:0] pix;
        logic          vld;
        logic          fd;
        logic [WW-1:0] win;
    } vec_t;
    vec_t tbl [16];

    task automatic check_w(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference window: pixel value is its raster index within the frame, mod 256.
    function automatic logic [WW-1:0] ref_win(input int row, input int col, input int w);
        logic [WW-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                v[(r*N+c)*DW +: DW] = 8'(((row - N + 1 + r) * w + (col - N + 1 + c)) & 255);
            end
        end
        return v;
    endfunction

    task automatic model_a();
        if (a_mrow >= N - 1 && a_mcol >= N - 1) a_q.push_back(ref_win(a_mrow, a_mcol, 4));
        if (a_mcol == 3) begin
            a_mcol = 0;
            a_mrow = (a_mrow == 3) ? 0 : a_mrow + 1;
        end else begin
            a_mcol++;
        end
    endtask

    task automatic model_b();
        if (b_mrow >= N - 1 && b_mcol >= N - 1) b_q.push_back(ref_win(b_mrow, b_mcol, 64));
        if (b_mcol == 63) begin
            b_mcol = 0;
            b_mrow = (b_mrow == 63) ? 0 : b_mrow + 1;
        end else begin
            b_mcol++;
        end
    endtask

    // Entered just after a rising edge; returns just after the edge that accepted the pixel.
    task automatic send_a(input logic [DW-1:0] p, input bit keep);
        int t;
        t = 0;
        a_in_valid = 1'b1;
        a_in_pix   = p;
        @(negedge clk);
        while (!a_in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!a_in_ready) begin
            checks++;
            errors++;
            $display("FAIL a_send_timeout actual=in_ready_low required=accept_within_50");
        end else begin
            model_a();
        end
        @(posedge clk);
        #1;
        if (!keep) a_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_model_a();
        a_mrow = 0;
        a_mcol = 0;
        a_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_out_valid && a_out_ready) begin
                a_wins++;
                a_log.push_back(a_out_win);
                if (a_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_window actual=%h required=none", a_out_win);
                end else begin
                    check_w("a_window", a_out_win, a_q.pop_front());
                end
            end
            if (b_out_valid && b_out_ready) begin
                b_wins++;
                if (b_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_window actual=%h required=none", b_out_win);
                end else begin
                    check_w("b_window", b_out_win, b_q.pop_front());
                end
            end
            if (a_frame_done) a_fd++;
            if (b_frame_done) b_fd++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int bub, nrdy;
        logic prevq, q;

        for (int i = 0; i < 16; i++) begin
            tbl[i].pix = 8'(i);
            tbl[i].vld = 1'b0;
            tbl[i].fd  = 1'b0;
            tbl[i].win = '0;
        end
        tbl[10].vld = 1'b1; tbl[10].win = W_FIRST;
        tbl[11].vld = 1'b1; tbl[11].win = W_BP;
        tbl[14].vld = 1'b1; tbl[14].win = W_3;
        tbl[15].vld = 1'b1; tbl[15].win = W_LAST;
        tbl[15].fd  = 1'b1;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_pix = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_pix = '0; b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_b("reset_out_valid", a_out_valid, 1'b0);
        check_b("reset_frame_done", a_frame_done, 1'b0);
        check_w("reset_out_win", a_out_win, '0);
        check_b("reset_in_ready", a_in_ready, 1'b1);
        rst_n = 1'b1;
        idle(1);

        // Basic frame, table driven
        a_wins = 0; a_fd = 0;
        for (int i = 0; i < 16; i++) begin
            send_a(tbl[i].pix, 1'b0);
            @(negedge clk);
            check_b("basic_out_valid", a_out_valid, tbl[i].vld);
            check_b("basic_frame_done", a_frame_done, tbl[i].fd);
            if (tbl[i].vld) check_w("basic_out_win", a_out_win, tbl[i].win);
            @(posedge clk);
            #1;
        end
        idle(3);
        check_i("basic_windows", a_wins, 4);
        check_i("basic_frame_done_count", a_fd, 1);
        check_i("basic_queue_left", a_q.size(), 0);

        // Backpressure while window {1,2,3,5,6,7,9,10,11} is valid
        a_wins = 0; a_fd = 0;
        for (int i = 0; i < 12; i++) send_a(8'(i), 1'b1);
        a_in_pix = 8'd12;
        a_out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_b("bp_in_ready", a_in_ready, 1'b0);
            check_b("bp_out_valid", a_out_valid, 1'b1);
            check_w("bp_out_win", a_out_win, W_BP);
            @(posedge clk);
            #1;
        end
        a_out_ready = 1'b1;
        for (int i = 12; i < 16; i++) send_a(8'(i), i != 15);
        idle(3);
        check_i("bp_windows", a_wins, 4);
        check_i("bp_frame_done_count", a_fd, 1);
        check_i("bp_queue_left", a_q.size(), 0);

        // Random input gaps across two frames
        a_wins = 0; a_fd = 0;
        a_log.delete();
        for (int i = 0; i < 32; i++) begin
            idle(int'($urandom_range(0, 2)));
            send_a(8'(i % 16), 1'b0);
        end
        idle(3);
        check_i("gap_windows", a_wins, 8);
        check_i("gap_frame_done_count", a_fd, 2);
        check_i("gap_queue_left", a_q.size(), 0);
        if (a_log.size() == 8) begin
            check_w("gap_frame2_first", a_log[4], W_FIRST);
            check_w("gap_frame2_last", a_log[7], W_LAST);
        end

        // Asynchronous reset mid-frame, then a clean frame
        for (int i = 0; i < 8; i++) send_a(8'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_b("rst_mid_out_valid", a_out_valid, 1'b0);
        check_b("rst_mid_frame_done", a_frame_done, 1'b0);
        reset_model_a();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_wins = 0; a_fd = 0;
        a_log.delete();
        for (int i = 0; i < 16; i++) send_a(8'(i), 1'b0);
        idle(3);
        check_i("rst_restart_windows", a_wins, 4);
        check_i("rst_restart_frame_done", a_fd, 1);
        check_i("rst_restart_queue_left", a_q.size(), 0);
        if (a_log.size() == 4) check_w("rst_restart_first", a_log[0], W_FIRST);

        // Reset while a stalled window is pending
        for (int i = 0; i < 11; i++) send_a(8'(i), 1'b0);
        a_out_ready = 1'b0;
        @(negedge clk);
        check_b("rst_stall_pre_valid", a_out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_b("rst_stall_out_valid", a_out_valid, 1'b0);
        check_w("rst_stall_out_win", a_out_win, '0);
        check_b("rst_stall_in_ready", a_in_ready, 1'b1);
        reset_model_a();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        idle(2);

        // Continuous throughput on the 64x64 instance
        b_wins = 0; b_fd = 0;
        bub = 0; nrdy = 0; prevq = 1'b0;
        b_in_valid = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            b_in_pix = 8'(i);
            @(negedge clk);
            if (b_out_valid !== prevq) bub++;
            if (!b_in_ready) nrdy++;
            q = (b_mrow >= N - 1 && b_mcol >= N - 1);
            model_b();
            prevq = q;
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        check_b("thru_last_valid", b_out_valid, prevq);
        idle(3);
        check_i("thru_windows", b_wins, 3844);
        check_i("thru_bubbles", bub, 0);
        check_i("thru_not_ready", nrdy, 0);
        check_i("thru_frame_done_count", b_fd, 1);
        check_i("thru_queue_left", b_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder of the convolution ALU: turns a raster-order pixel stream into DWIDTH_SLICE x DWIDTH_SLICE pixel windows.
- Each window is packed onto a flat bus, in the same layout the ALU's din input consumes.
- Holds DWIDTH_SLICE-1 line buffers plus a register window.
- Valid/ready handshake on both sides; no edge padding ("valid" convolution only).

Parameters:
- DWIDTH_DAT, 8, pixel width in bits (matches `dwidth_dat).
- DWIDTH_SLICE, 3, window edge N (matches `dwidth_slice); legal values 2..7.
- IMG_WIDTH, 64, pixels per image row; must be >= DWIDTH_SLICE.
- IMG_HEIGHT, 64, rows per frame; must be >= DWIDTH_SLICE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pixel present on in_pix.
- in_ready  out  1  block accepts the pixel this cycle.
- in_pix  in  DWIDTH_DAT  pixel, raster order, top-left first.
- out_valid  out  1  window present on out_win.
- out_ready  in  1  downstream takes the window this cycle.
- out_win  out  DWIDTH_SLICE*DWIDTH_SLICE*DWIDTH_DAT  packed window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Accept: in_valid && in_ready. Transfer: out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational and the only stall mechanism. No bubble under continuous flow.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance on each accept only.
- col wraps to 0 with row+1. At col=IMG_WIDTH-1, row=IMG_HEIGHT-1 both wrap to 0, and frame_done pulses on the next cycle.
- Line buffers: N-1 circular buffers, each IMG_WIDTH deep, addressed by col.
  - On accept, buffer k is written with the value buffer k-1 held at that col; buffer 0 takes in_pix.
  - Write and read of the same address happen in the same cycle: the read returns the old data.
- Window registers: N x N. On accept, every row shifts left by one column.
  - The new right column, top to bottom, is {buffer N-2 .. buffer 0 at col, in_pix}.
- Packing: element index idx = r*N + c occupies bits [(idx+1)*DWIDTH_DAT-1 : idx*DWIDTH_DAT].
  - r=0 is the oldest (top) row; c=0 is the leftmost column.
  - Element idx pairs with kernel element idx in the ALU.
- Output rule:
  - On an accept with row >= N-1 and col >= N-1 (values before the increment), out_valid is set on the next edge, with out_win = the updated window.
  - Latency is 1 cycle from accept to out_valid.
  - On an accept that does not meet the condition, out_valid clears if a transfer also happens; otherwise it holds.
- Hold rule: while out_valid && !out_ready, out_win, the window registers, the line buffers and the counters are all frozen.
- Windows that straddle a row boundary (col < N-1) carry stale columns and are never emitted.
- Windows per frame = (IMG_WIDTH-N+1)*(IMG_HEIGHT-N+1).
- Reset (asynchronous, any time, including mid-frame):
  - col=0, row=0, out_valid=0, frame_done=0, out_win=0, window registers=0.
  - Line buffer contents are don't-care: they are overwritten before any emitted window uses them.
  - The next accepted pixel is treated as the top-left of a new frame.
- in_valid low: no state change. out_valid holds until it transfers.
- Simultaneous transfer and a qualifying accept: the new window replaces the old one with out_valid staying 1 (back-to-back).

Test Plan:
- Basic frame. N=3, W=8, IMG 4x4, pixels 0..15 streamed, out_ready=1.
  - Exactly 4 windows.
  - First window appears 1 cycle after pixel 10 is accepted, with idx0..8 = {0,1,2,4,5,6,8,9,10}.
  - Last window = {5,6,7,9,10,11,13,14,15}.
  - frame_done pulses once, 1 cycle after pixel 15 is accepted.
- Backpressure. Same stream; out_ready=0 for 5 cycles while window {1,2,3,5,6,7,9,10,11} is valid.
  - in_ready=0 and out_win stable throughout.
  - No pixel is lost; the remaining windows match the basic frame.
- Input gaps. in_valid toggled randomly over 2 consecutive frames (pixel value = index mod 16).
  - 8 windows, identical to the gap-free run.
  - Frame 2 first window = {0,1,2,4,5,6,8,9,10}.
  - Row-straddling windows are never emitted.
- Reset mid-frame. Assert rst_n=0 asynchronously after pixel 7.
  - out_valid=0 and frame_done=0 immediately.
  - Restarting with pixels 0..15 reproduces the basic-frame output exactly.
- Continuous throughput. IMG 64x64, N=3, in_valid=1, out_ready=1.
  - 3844 windows total.
  - After the first window of each row, one window per cycle with no bubbles.
  - Every out_win is checked against a reference model of the window layout.
